// File: rtl/seg_scan_driver.sv
// Binary-to-BCD (sequential double-dabble) feeding a two-digit common-anode seven-segment scanner.
// Optional leading-zero blanking of the tens digit is enabled by defining SEG_BLANK_EN.
//
// state  | meaning
// S_IDLE | waiting for num_valid; display holds the last committed value
// S_CONV | shift-add-3 iterations running, busy=1, commit on the 8th
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] num,
  input  logic       num_valid,
  output logic       busy,
  output logic [7:0] seg,
  output logic [1:0] dig
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE,
    S_CONV
  } state_t;

  state_t      state_q, state_d;
  logic        load, step, commit;
  logic [2:0]  iter_q;
  logic [19:0] sr_q, sr_adj, sr_next;
  logic [3:0]  hund_q, tens_q, units_q;
  logic [DIV_W-1:0] div_q;
  logic        sel_q;
  logic        overflow;
  logic [7:0]  units_pat, tens_pat, seg_d;
  logic [1:0]  dig_d;

  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (num_valid) begin
          load    = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        step = 1'b1;
        if (iter_q == 3'd7) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble iteration: correct each BCD nibble, then shift the whole register.
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
    if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
    if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
    sr_next = sr_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      iter_q  <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      if (load) begin
        sr_q   <= {12'd0, num};
        iter_q <= '0;
      end else if (step) begin
        sr_q   <= sr_next;
        iter_q <= iter_q + 3'd1;
      end
      if (commit) begin
        hund_q  <= sr_next[19:16];
        tens_q  <= sr_next[15:12];
        units_q <= sr_next[11:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      sel_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      sel_q <= ~sel_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    overflow  = (hund_q != 4'd0);
    units_pat = overflow ? SEG_DASH : seg_pat(units_q);
`ifdef SEG_BLANK_EN
    if (overflow)              tens_pat = SEG_DASH;
    else if (tens_q == 4'd0)   tens_pat = SEG_BLANK;
    else                       tens_pat = seg_pat(tens_q);
`else
    tens_pat  = overflow ? SEG_DASH : seg_pat(tens_q);
`endif
    seg_d = sel_q ? tens_pat : units_pat;
    dig_d = sel_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dig <= 2'b11;
    end else begin
      seg <= seg_d;
      dig <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4: vector table of conversions plus
// hand-written reset, busy-rejection, commit-cycle and mid-conversion reset sequences.
module tb_seg_scan_driver;

  localparam int SD = 4;
`ifdef SEG_BLANK_EN
  localparam logic [7:0] T0 = 8'hFF;
`else
  localparam logic [7:0] T0 = 8'hC0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num = 8'd0;
  logic       num_valid = 1'b0;
  logic       busy;
  logic [7:0] seg;
  logic [1:0] dig;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .num(num), .num_valid(num_valid),
    .busy(busy), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [7:0] u;
    logic [7:0] t;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] n);
    num = n;
    num_valid = 1'b1;
    tick();
    num_valid = 1'b0;
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 20) begin
      c++;
      tick();
    end
  endtask

  task automatic capture(output logic [7:0] u, output logic [7:0] t, output int bad);
    u = 8'h00;
    t = 8'h00;
    bad = 0;
    repeat (2 * SD + 1) begin
      tick();
      if (dig == 2'b10)      u = seg;
      else if (dig == 2'b01) t = seg;
      else                   bad++;
    end
  endtask

  initial begin
    int c, bad;
    logic [7:0] u, t;

    vecs[0]  = '{8'd29,  8'h90, 8'hA4};
    vecs[1]  = '{8'd0,   8'hC0, T0};
    vecs[2]  = '{8'd7,   8'hF8, T0};
    vecs[3]  = '{8'd100, 8'hBF, 8'hBF};
    vecs[4]  = '{8'd255, 8'hBF, 8'hBF};
    vecs[5]  = '{8'd99,  8'h90, 8'h90};
    vecs[6]  = '{8'd10,  8'hC0, 8'hF9};
    vecs[7]  = '{8'd9,   8'h90, T0};
    vecs[8]  = '{8'd38,  8'h80, 8'hB0};
    vecs[9]  = '{8'd61,  8'hF9, 8'h82};
    vecs[10] = '{8'd73,  8'hB0, 8'hF8};

    // reset held three cycles
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("rst_seg", seg, 8'hFF);
      check("rst_dig", dig, 2'b11);
      check("rst_busy", busy, 1'b0);
    end
    rst = 1'b0;
    // dwell: units for SD cycles after release, then tens for SD cycles
    for (int k = 1; k <= 2 * SD; k++) begin
      tick();
      check($sformatf("dwell_dig_%0d", k), dig, (k <= SD) ? 2'b10 : 2'b01);
      check($sformatf("dwell_seg_%0d", k), seg, (k <= SD) ? 8'hC0 : T0);
    end

    for (int i = 0; i < 11; i++) begin
      strobe(vecs[i].n);
      count_busy(c);
      check($sformatf("busy_len_%0d", vecs[i].n), c, 8);
      capture(u, t, bad);
      check($sformatf("units_%0d", vecs[i].n), u, vecs[i].u);
      check($sformatf("tens_%0d", vecs[i].n), t, vecs[i].t);
      check($sformatf("onehot_%0d", vecs[i].n), bad, 0);
    end

    // strobe 88 two cycles into converting 14 must be ignored
    strobe(8'd14);
    tick();
    num = 8'd88;
    num_valid = 1'b1;
    tick();
    num_valid = 1'b0;
    count_busy(c);
    check("rej_busy_rest", c, 6);
    capture(u, t, bad);
    check("rej_units", u, 8'h99);
    check("rej_tens", t, 8'hF9);

    // strobe coinciding with the commit edge is dropped
    strobe(8'd56);
    repeat (7) tick();
    check("commit_pre_busy", busy, 1'b1);
    num = 8'd33;
    num_valid = 1'b1;
    tick();
    num_valid = 1'b0;
    check("commit_busy_0", busy, 1'b0);
    tick();
    check("commit_busy_1", busy, 1'b0);
    capture(u, t, bad);
    check("commit_units", u, 8'h92 == 8'h92 ? 8'h82 : 8'h00);
    check("commit_tens", t, 8'h92);

    // reset at the fourth busy cycle of converting 45
    strobe(8'd45);
    repeat (3) tick();
    check("midrst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_seg", seg, 8'hFF);
    check("midrst_dig", dig, 2'b11);
    check("midrst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_rel_dig", dig, 2'b10);
    check("midrst_rel_seg", seg, 8'hC0);
    check("midrst_rel_busy", busy, 1'b0);
    capture(u, t, bad);
    check("midrst_units", u, 8'hC0);
    check("midrst_tens", t, T0);
    check("midrst_onehot", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
